// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: forwarding selects, load-use and branch
// hazard handling, a multicycle-unit wait FSM with timeout, and
// saturating stall/flush performance counters.
module pipeline_controller #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rs1_e,
  input  logic [4:0]           rs2_e,
  input  logic [4:0]           rd_e,
  input  logic [1:0]           res_src_e,
  input  logic                 pc_src_e,
  input  logic                 mc_start_e,
  input  logic                 mc_done,
  input  logic [4:0]           rd_m,
  input  logic [4:0]           rd_w,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_m,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic                 mc_go,
  output logic                 mc_busy,
  output logic                 mc_error,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int TW = $clog2(MC_TIMEOUT) + 1;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t                state_reg;
  logic [TW-1:0]         timer_reg;
  logic                  mc_error_reg;
  logic [CNT_WIDTH-1:0]  stall_cycles_reg;
  logic [CNT_WIDTH-1:0]  flush_count_reg;

  logic load_use;
  logic timeout_hit;

  assign load_use    = (res_src_e == 2'b01) && (rd_e != 5'd0) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign timeout_hit = (timer_reg == TW'(MC_TIMEOUT - 1));

  assign mc_busy      = (state_reg == MC_WAIT);
  assign mc_error     = mc_error_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

  // Operand forwarding: the M-stage result is newer, so it wins over W.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_e))      forward_a_e = 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e)) forward_a_e = 2'b01;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_e))      forward_b_e = 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e)) forward_b_e = 2'b01;
  end

  // Stall/flush/start decode; everything is held low while reset is asserted.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    mc_go   = 1'b0;
    if (rst_n) begin
      if (state_reg == MC_WAIT) begin
        // Freeze F/D/E and bubble M until the unit completes; on the done
        // cycle all stalls drop so the result advances immediately.
        if (!mc_done) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
      end else if (pc_src_e) begin
        // A taken branch squashes the wrong-path instructions, even if a
        // load-use hazard was also detected this cycle.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        mc_go = mc_start_e;
      end
    end
  end

  // Multicycle wait FSM with timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      timer_reg    <= '0;
      mc_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mc_start_e && !pc_src_e) begin
            state_reg <= MC_WAIT;
            timer_reg <= '0;
          end
        end
        MC_WAIT: begin
          timer_reg <= timer_reg + 1'b1;
          if (mc_done) begin
            state_reg <= RUN;
          end else if (timeout_hit) begin
            state_reg    <= RUN;
            mc_error_reg <= 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // Saturating performance counters for front-end stalls and D flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (stall_f && (stall_cycles_reg != '1)) stall_cycles_reg <= stall_cycles_reg + 1'b1;
      if (flush_d && (flush_count_reg != '1))  flush_count_reg  <= flush_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: two instances (default timeout / wide
// counters, and short timeout / narrow counters) driven by the same inputs
// and checked every cycle against a behavioural model, plus directed checks.
module tb_pipeline_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] res_src_e;
  logic pc_src_e, mc_start_e, mc_done, reg_write_m, reg_write_w;

  logic sf[2], sd[2], se[2], fd[2], fe[2], fm[2], go[2], busy[2], err[2];
  logic [1:0] fa[2], fb[2];
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  pipeline_controller #(.MC_TIMEOUT(64), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .res_src_e(res_src_e), .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
    .mc_done(mc_done), .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .stall_f(sf[0]), .stall_d(sd[0]), .stall_e(se[0]), .flush_d(fd[0]), .flush_e(fe[0]), .flush_m(fm[0]),
    .forward_a_e(fa[0]), .forward_b_e(fb[0]), .mc_go(go[0]), .mc_busy(busy[0]), .mc_error(err[0]),
    .stall_cycles(sc0), .flush_count(fc0));

  pipeline_controller #(.MC_TIMEOUT(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .res_src_e(res_src_e), .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
    .mc_done(mc_done), .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .stall_f(sf[1]), .stall_d(sd[1]), .stall_e(se[1]), .flush_d(fd[1]), .flush_e(fe[1]), .flush_m(fm[1]),
    .forward_a_e(fa[1]), .forward_b_e(fb[1]), .mc_go(go[1]), .mc_busy(busy[1]), .mc_error(err[1]),
    .stall_cycles(sc1), .flush_count(fc1));

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state per instance
  bit m_busy[2];
  int m_tmr[2];
  bit m_err[2];
  int m_sc[2], m_fc[2];
  int to_v[2] = '{64, 4};
  int mx_v[2] = '{65535, 15};
  bit e_sf[2], e_sd[2], e_se[2], e_fd[2], e_fe[2], e_fm[2], e_go[2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_tmr[k] = 0; m_err[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
  endtask

  task automatic expect_outputs(input int k);
    logic rst, lu;
    rst = (k == 0) ? rst_n_a : rst_n_b;
    lu  = (res_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
    e_sf[k] = 0; e_sd[k] = 0; e_se[k] = 0; e_fd[k] = 0; e_fe[k] = 0; e_fm[k] = 0; e_go[k] = 0;
    if (!rst) return;
    if (m_busy[k]) begin
      if (!mc_done) begin e_sf[k] = 1; e_sd[k] = 1; e_se[k] = 1; e_fm[k] = 1; end
    end else if (pc_src_e) begin
      e_fd[k] = 1; e_fe[k] = 1;
    end else begin
      if (lu) begin e_sf[k] = 1; e_sd[k] = 1; e_fe[k] = 1; end
      e_go[k] = mc_start_e;
    end
  endtask

  task automatic model_edge(input int k);
    logic rst;
    rst = (k == 0) ? rst_n_a : rst_n_b;
    if (!rst) begin model_reset(k); return; end
    if (e_sf[k] && m_sc[k] < mx_v[k]) m_sc[k]++;
    if (e_fd[k] && m_fc[k] < mx_v[k]) m_fc[k]++;
    if (!m_busy[k]) begin
      if (mc_start_e && !pc_src_e) begin m_busy[k] = 1; m_tmr[k] = 0; end
    end else if (mc_done) begin
      m_busy[k] = 0;
    end else if (m_tmr[k] == to_v[k] - 1) begin
      m_busy[k] = 0; m_err[k] = 1;
    end else begin
      m_tmr[k]++;
    end
  endtask

  task automatic check_comb(input int k);
    expect_outputs(k);
    chk("stall_f", k, 32'(sf[k]), 32'(e_sf[k]));
    chk("stall_d", k, 32'(sd[k]), 32'(e_sd[k]));
    chk("stall_e", k, 32'(se[k]), 32'(e_se[k]));
    chk("flush_d", k, 32'(fd[k]), 32'(e_fd[k]));
    chk("flush_e", k, 32'(fe[k]), 32'(e_fe[k]));
    chk("flush_m", k, 32'(fm[k]), 32'(e_fm[k]));
    chk("mc_go",   k, 32'(go[k]), 32'(e_go[k]));
    chk("forward_a_e", k, 32'(fa[k]), 32'(fwd(rs1_e)));
    chk("forward_b_e", k, 32'(fb[k]), 32'(fwd(rs2_e)));
  endtask

  task automatic check_reg(input int k);
    chk("mc_busy",  k, 32'(busy[k]), 32'(m_busy[k]));
    chk("mc_error", k, 32'(err[k]),  32'(m_err[k]));
    chk("stall_cycles", k, (k == 0) ? 32'(sc0) : 32'(sc1), 32'(m_sc[k]));
    chk("flush_count",  k, (k == 0) ? 32'(fc0) : 32'(fc1), 32'(m_fc[k]));
  endtask

  // One clock: check combinational outputs mid-cycle, advance, check state.
  task automatic step();
    #4;
    check_comb(0); check_comb(1);
    @(posedge clk);
    model_edge(0); model_edge(1);
    #1;
    check_reg(0); check_reg(1);
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    res_src_e = 0; pc_src_e = 0; mc_start_e = 0; mc_done = 0; reg_write_m = 0; reg_write_w = 0;
  endtask

  initial begin
    rst_n_a = 0; rst_n_b = 0;
    clear_inputs();
    model_reset(0); model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    // Reset forces hazard outputs low even with a load-use pattern present
    res_src_e = 2'b01; rd_e = 5; rs1_d = 5;
    step();
    rst_n_a = 1;
    step();  // load-use: 1-cycle stall
    chk("lu_stall_cycles", 0, 32'(sc0), 32'd1);
    clear_inputs();
    step();
    // Branch with simultaneous load-use
    res_src_e = 2'b01; rd_e = 5; rs2_d = 5; pc_src_e = 1;
    step();
    chk("br_flush_count", 0, 32'(fc0), 32'd1);
    chk("br_stall_cycles", 0, 32'(sc0), 32'd1);
    clear_inputs();
    // Forwarding priority
    rd_m = 7; rd_w = 7; reg_write_m = 1; reg_write_w = 1; rs1_e = 7;
    step();
    chk("fwd_m", 0, 32'(fa[0]), 32'd2);
    rd_m = 0;
    step();
    chk("fwd_w", 0, 32'(fa[0]), 32'd1);
    clear_inputs();

    // Multicycle: restart counters, then 10 stall cycles and done on the 11th
    rst_n_a = 0; #1; model_reset(0);
    step();
    rst_n_a = 1;
    mc_start_e = 1;
    step();
    mc_start_e = 0;
    repeat (10) step();
    mc_done = 1;
    step();
    mc_done = 0;
    chk("mc_back_to_run", 0, 32'(busy[0]), 32'd0);
    chk("mc_stall_cycles", 0, 32'(sc0), 32'd10);
    step();

    // Timeout on the short-timeout instance
    rst_n_b = 1;
    mc_start_e = 1;
    step();
    mc_start_e = 0;
    repeat (3) step();
    chk("to_still_busy", 1, 32'(busy[1]), 32'd1);
    step();
    chk("to_run", 1, 32'(busy[1]), 32'd0);
    chk("to_error", 1, 32'(err[1]), 32'd1);
    repeat (3) step();
    chk("to_error_sticky", 1, 32'(err[1]), 32'd1);

    // Reset asserted while waiting acts without a clock edge
    chk("mid_busy_pre", 0, 32'(busy[0]), 32'd1);
    rst_n_a = 0; rst_n_b = 0;
    #1;
    chk("mid_busy", 0, 32'(busy[0]), 32'd0);
    chk("mid_stall_f", 0, 32'(sf[0]), 32'd0);
    chk("mid_stall_d", 0, 32'(sd[0]), 32'd0);
    chk("mid_stall_e", 0, 32'(se[0]), 32'd0);
    chk("err_cleared", 1, 32'(err[1]), 32'd0);
    model_reset(0); model_reset(1);
    mc_done = 1;
    step();
    rst_n_a = 1; rst_n_b = 1;
    step();
    mc_done = 0;
    chk("mid_after", 0, 32'(busy[0]), 32'd0);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      res_src_e   = 2'($urandom_range(0, 3));
      pc_src_e    = ($urandom_range(0, 7) == 0);
      mc_start_e  = ($urandom_range(0, 5) == 0);
      mc_done     = ($urandom_range(0, 9) == 0);
      reg_write_m = 1'($urandom);
      reg_write_w = 1'($urandom);
      if (!rst_n_a) rst_n_a = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 299) == 0) begin rst_n_a = 0; model_reset(0); end
      if (!rst_n_b) rst_n_b = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 299) == 0) begin rst_n_b = 0; model_reset(1); end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
